// File: rtl/pv_meas_defs.sv
// Shared definitions for the PV measurement path.
// Holds the edge_period_meter state encoding and the default counter/averaging
// widths. The downstream frequency logic imports the same package so both sides
// agree on the encodings.
package pv_meas_defs;

  typedef enum logic [1:0] {
    StWaitFirst = 2'd0,
    StMeasure   = 2'd1,
    StLost      = 2'd2
  } meas_state_e;

  localparam int unsigned DefCntW    = 24;
  localparam int unsigned DefAvgLog2 = 3;

endpackage

// File: rtl/period_averager.sv
// Block averager for accepted periods.
// Sums 2^AVG_LOG2 samples and publishes their truncated mean.
//   sclk         : system clock, rising edge active
//   rst          : synchronous active-high reset
//   sample       : accepted period in sclk cycles
//   sample_valid : sample is valid this cycle
//   clear        : drop the partial sum (signal loss); avg_period is kept
//   avg_period   : mean of the last block of samples
//   avg_valid    : one-cycle strobe, avg_period updated
module period_averager
  import pv_meas_defs::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned AVG_LOG2 = DefAvgLog2
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [CNT_W-1:0] sample,
  input  logic             sample_valid,
  input  logic             clear,
  output logic [CNT_W-1:0] avg_period,
  output logic             avg_valid
);

  // The extra AVG_LOG2 bits hold a full block of maximum-size samples.
  localparam int unsigned AccW = CNT_W + AVG_LOG2;
  localparam int unsigned SmpW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SmpW-1:0] LastSmp = SmpW'((32'd1 << AVG_LOG2) - 32'd1);

  logic [AccW-1:0]  acc_q, acc_d;
  logic [SmpW-1:0]  smp_q, smp_d;
  logic [CNT_W-1:0] avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic [AccW-1:0]  sum;

  always_comb begin
    sum         = acc_q + AccW'(sample);
    acc_d       = acc_q;
    smp_d       = smp_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (sample_valid) begin
      if (smp_q == LastSmp) begin
        avg_d       = CNT_W'(sum >> AVG_LOG2);
        avg_valid_d = 1'b1;
        acc_d       = '0;
        smp_d       = '0;
      end else begin
        acc_d = sum;
        smp_d = smp_q + SmpW'(1);
      end
    end else if (clear) begin
      acc_d = '0;
      smp_d = '0;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      acc_q       <= '0;
      smp_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      smp_q       <= smp_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg_period = avg_q;
  assign avg_valid  = avg_valid_q;

endmodule

// File: rtl/edge_period_meter.sv
// Measures the sclk period between accepted rising edges of the squared PV wave.
// Edges closer than MIN_PERIOD to the last accepted edge are glitches and are
// ignored; TIMEOUT cycles without an accepted edge declares signal loss.
//   sclk         : system clock, rising edge active
//   rst          : synchronous active-high reset
//   rising_edge  : one-cycle pulse per negative-to-positive transition
//   period       : last accepted period in sclk cycles
//   period_valid : one-cycle strobe, period updated
//   avg_period   : truncated mean of the last 2^AVG_LOG2 periods
//   avg_valid    : one-cycle strobe, avg_period updated
//   signal_lost  : high while no accepted edge arrived within TIMEOUT
module edge_period_meter
  import pv_meas_defs::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned AVG_LOG2   = DefAvgLog2,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned TIMEOUT    = (32'd1 << CNT_W) - 32'd1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             rising_edge,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] avg_period,
  output logic             avg_valid,
  output logic             signal_lost
);

  localparam logic [CNT_W-1:0] MinCnt     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             lost_q, lost_d;
  logic             accept;
  logic             clear_avg;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    lost_d         = lost_q;
    accept         = 1'b0;
    clear_avg      = 1'b0;
    unique case (state_q)
      StWaitFirst: begin
        cnt_d = '0;
        // First edge only opens the measurement window.
        if (rising_edge) begin
          cnt_d   = CNT_W'(1);
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        // An edge on the timeout cycle wins; TIMEOUT > MIN_PERIOD so it is accepted.
        if (rising_edge && (cnt_q >= MinCnt)) begin
          accept         = 1'b1;
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          cnt_d          = CNT_W'(1);
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = StLost;
          lost_d    = 1'b1;
          clear_avg = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLost: begin
        cnt_d = '0;
        if (rising_edge) begin
          cnt_d   = CNT_W'(1);
          lost_d  = 1'b0;
          state_d = StMeasure;
        end
      end
      default: begin
        state_d = StWaitFirst;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q        <= StWaitFirst;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      lost_q         <= lost_d;
    end
  end

  period_averager #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_period_averager (
    .sclk         (sclk),
    .rst          (rst),
    .sample       (cnt_q),
    .sample_valid (accept),
    .clear        (clear_avg),
    .avg_period   (avg_period),
    .avg_valid    (avg_valid)
  );

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign signal_lost  = lost_q;

endmodule
